// File: rtl/md_pkg.sv
// Shared types and constants for the MULT/DIV issue controller.
// State encoding is fixed at 2 bits: IDLE=0, ISSUE=1, BUSY=2, DONE=3.
package md_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_BUSY  = 2'd2,
    ST_DONE  = 2'd3
  } md_state_e;

  typedef enum logic {
    OP_MULT = 1'b0,
    OP_DIV  = 1'b1
  } md_op_e;

  localparam int unsigned TIMEOUT_DEFAULT = 40;
  localparam int unsigned WD_WIDTH        = 6;

  localparam logic [4:0]  RSTATUS_REG   = 5'd30;
  localparam logic [31:0] MULT_EXC_CODE = 32'd4;
  localparam logic [31:0] DIV_EXC_CODE  = 32'd5;

  // rstatus value for a failed operation, already zero-extended to 32 bits
  function automatic logic [31:0] exc_code(input md_op_e op);
    return (op == OP_DIV) ? DIV_EXC_CODE : MULT_EXC_CODE;
  endfunction

endpackage

// File: rtl/md_watchdog.sv
// Cycle counter for the BUSY phase: synchronous clear, count enable and a
// terminal-count flag that is high while the count equals TERMINAL.
module md_watchdog #(
  parameter int unsigned WIDTH    = 6,
  parameter int unsigned TERMINAL = 39
) (
  input  logic clock,
  input  logic reset_n,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam logic [WIDTH-1:0] TERM = WIDTH'(TERMINAL);

  logic [WIDTH-1:0] count_reg;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count_reg <= '0;
    end else if (clr) begin
      count_reg <= '0;
    end else if (en) begin
      count_reg <= count_reg + WIDTH'(1);
    end
  end

  assign tc = (count_reg == TERM);

endmodule

// File: rtl/md_issue_ctrl.sv
// Sequences one MULT/DIV from X through multdiv: latch, pulse, stall until
// result or watchdog timeout, then a single-cycle writeback to rd or rstatus.
module md_issue_ctrl
  import md_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        x_is_mult,
  input  logic        x_is_div,
  input  logic [4:0]  x_rd,
  input  logic [31:0] x_opA,
  input  logic [31:0] x_opB,
  input  logic        x_flush,
  output logic [31:0] md_opA,
  output logic [31:0] md_opB,
  output logic        md_ctrl_mult,
  output logic        md_ctrl_div,
  input  logic [31:0] md_result,
  input  logic        md_exception,
  input  logic        md_resultRDY,
  output logic        stall,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data
);

  md_state_e   state_reg, state_next;
  md_op_e      op_reg;
  logic [4:0]  rd_reg;
  logic [31:0] opa_reg, opb_reg;
  logic        ctrl_mult_reg, ctrl_div_reg;

  logic        wb_valid_reg, wb_valid_next;
  logic [4:0]  wb_rd_reg, wb_rd_next;
  logic [31:0] wb_data_reg, wb_data_next;

  logic md_req, accept;
  logic finish, finish_exc;
  logic wd_clr, wd_en, wd_tc;

  assign md_req = x_is_mult | x_is_div;
  assign accept = (state_reg == ST_IDLE) & md_req & ~x_flush;

  // Count is 0 in the first BUSY cycle, so tc fires in BUSY cycle TIMEOUT-1
  md_watchdog #(
    .WIDTH    (WD_WIDTH),
    .TERMINAL (TIMEOUT - 1)
  ) u_watchdog (
    .clock   (clock),
    .reset_n (reset_n),
    .clr     (wd_clr),
    .en      (wd_en),
    .tc      (wd_tc)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    wd_clr     = 1'b0;
    wd_en      = 1'b0;
    finish     = 1'b0;
    finish_exc = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (accept) begin
          state_next = ST_ISSUE;
          wd_clr     = 1'b1;
        end
      end
      // RDY may still be high from the previous op, so it is not looked at here
      ST_ISSUE: begin
        state_next = x_flush ? ST_IDLE : ST_BUSY;
      end
      ST_BUSY: begin
        wd_en = 1'b1;
        if (x_flush) begin
          state_next = ST_IDLE;
        end else if (md_resultRDY) begin
          state_next = ST_DONE;
          finish     = 1'b1;
          finish_exc = md_exception;
        end else if (wd_tc) begin
          state_next = ST_DONE;
          finish     = 1'b1;
          finish_exc = 1'b1;
        end
      end
      ST_DONE: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Writeback is formed on the BUSY->DONE edge so it is registered in DONE
  always_comb begin
    wb_valid_next = 1'b0;
    wb_rd_next    = '0;
    wb_data_next  = '0;
    if (finish) begin
      if (finish_exc) begin
        wb_valid_next = 1'b1;
        wb_rd_next    = RSTATUS_REG;
        wb_data_next  = exc_code(op_reg);
      end else begin
        wb_valid_next = (rd_reg != 5'd0);
        wb_rd_next    = rd_reg;
        wb_data_next  = md_result;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      op_reg        <= OP_MULT;
      rd_reg        <= '0;
      opa_reg       <= '0;
      opb_reg       <= '0;
      ctrl_mult_reg <= 1'b0;
      ctrl_div_reg  <= 1'b0;
      wb_valid_reg  <= 1'b0;
      wb_rd_reg     <= '0;
      wb_data_reg   <= '0;
    end else begin
      if (accept) begin
        op_reg  <= x_is_mult ? OP_MULT : OP_DIV;
        rd_reg  <= x_rd;
        opa_reg <= x_opA;
        opb_reg <= x_opB;
      end
      // MULT takes priority when X reports both
      ctrl_mult_reg <= accept & x_is_mult;
      ctrl_div_reg  <= accept & ~x_is_mult;
      wb_valid_reg  <= wb_valid_next;
      wb_rd_reg     <= wb_rd_next;
      wb_data_reg   <= wb_data_next;
    end
  end

  assign stall = accept | (state_reg == ST_ISSUE) | (state_reg == ST_BUSY);

  assign md_opA       = opa_reg;
  assign md_opB       = opb_reg;
  assign md_ctrl_mult = ctrl_mult_reg;
  assign md_ctrl_div  = ctrl_div_reg;
  assign wb_valid     = wb_valid_reg;
  assign wb_rd        = wb_rd_reg;
  assign wb_data      = wb_data_reg;

endmodule

// File: tb/tb_md_issue_ctrl.sv
// Testbench for md_issue_ctrl: directed table, reset sequence, then random
// transactions checked against a cycle-level model of the operation timeline.
module tb_md_issue_ctrl;

  localparam int TIMEOUT = 40;

  logic        clock = 1'b0;
  logic        reset_n = 1'b1;
  logic        x_is_mult = 1'b0, x_is_div = 1'b0;
  logic [4:0]  x_rd = '0;
  logic [31:0] x_opA = '0, x_opB = '0;
  logic        x_flush = 1'b0;
  logic [31:0] md_opA, md_opB;
  logic        md_ctrl_mult, md_ctrl_div;
  logic [31:0] md_result = '0;
  logic        md_exception = 1'b0, md_resultRDY = 1'b0;
  logic        stall, wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;

  int checks = 0;
  int failures = 0;

  md_issue_ctrl #(.TIMEOUT(TIMEOUT)) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .x_is_mult    (x_is_mult),
    .x_is_div     (x_is_div),
    .x_rd         (x_rd),
    .x_opA        (x_opA),
    .x_opB        (x_opB),
    .x_flush      (x_flush),
    .md_opA       (md_opA),
    .md_opB       (md_opB),
    .md_ctrl_mult (md_ctrl_mult),
    .md_ctrl_div  (md_ctrl_div),
    .md_result    (md_result),
    .md_exception (md_exception),
    .md_resultRDY (md_resultRDY),
    .stall        (stall),
    .wb_valid     (wb_valid),
    .wb_rd        (wb_rd),
    .wb_data      (wb_data)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        is_mult;
    logic        is_div;
    logic [4:0]  rd;
    logic [31:0] a;
    logic [31:0] b;
    int          rdy_at;    // cycle RDY is driven (0 = never)
    logic        exc;
    logic [31:0] result;
    int          flush_at;  // cycle x_flush is driven (0 = never)
    logic        stale_rdy; // RDY also high during ISSUE
    int          e_done;    // DONE cycle, 0 when the op is flushed
    logic        e_mult;
    logic        e_valid;
    logic [4:0]  e_rd;
    logic [31:0] e_data;
  } txn_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic txn_t mk(input logic im, input logic id, input logic [4:0] rd,
                              input logic [31:0] a, input logic [31:0] b, input int rdy_at,
                              input logic exc, input logic [31:0] res, input int flush_at,
                              input logic stale, input int e_done, input logic e_mult,
                              input logic e_valid, input logic [4:0] e_rd, input logic [31:0] e_data);
    txn_t t;
    t.is_mult = im;  t.is_div = id;  t.rd = rd;  t.a = a;  t.b = b;
    t.rdy_at = rdy_at;  t.exc = exc;  t.result = res;  t.flush_at = flush_at;
    t.stale_rdy = stale;  t.e_done = e_done;  t.e_mult = e_mult;
    t.e_valid = e_valid;  t.e_rd = e_rd;  t.e_data = e_data;
    return t;
  endfunction

  // Reference: the op completes one cycle after RDY is seen in BUSY (cycles
  // 2..TIMEOUT+1); otherwise the watchdog forces DONE at TIMEOUT+2. A flush
  // before DONE cancels everything.
  function automatic txn_t model(input txn_t t_in);
    txn_t t;
    logic timed_out, exc;
    int   d0;
    t = t_in;
    timed_out = (t.rdy_at == 0) || (t.rdy_at > TIMEOUT + 1);
    d0 = timed_out ? TIMEOUT + 2 : t.rdy_at + 1;
    t.e_mult = t.is_mult;
    if (t.flush_at >= d0) t.flush_at = 0;
    if (t.flush_at != 0) begin
      t.e_done = 0;  t.e_valid = 1'b0;  t.e_rd = '0;  t.e_data = '0;
    end else begin
      exc = timed_out | t.exc;
      t.e_done  = d0;
      t.e_valid = exc | (t.rd != 5'd0);
      t.e_rd    = exc ? 5'd30 : t.rd;
      t.e_data  = exc ? (t.is_mult ? 32'd4 : 32'd5) : t.result;
    end
    return t;
  endfunction

  // Entered just after a rising edge with the DUT in IDLE; cycle 0 presents the op.
  task automatic run_txn(input txn_t t, input string tag);
    int   last;
    logic flushed, in_x, is_rdy;
    flushed = (t.e_done == 0);
    last = flushed ? t.flush_at + 1 : t.e_done;
    for (int c = 0; c <= last; c++) begin
      in_x = flushed ? (c <= t.flush_at) : 1'b1;
      is_rdy = (t.rdy_at != 0) && (c == t.rdy_at);
      x_is_mult    = in_x & t.is_mult;
      x_is_div     = in_x & t.is_div;
      x_rd         = (c == 0) ? t.rd : 5'($urandom);
      x_opA        = (c == 0) ? t.a : $urandom;
      x_opB        = (c == 0) ? t.b : $urandom;
      x_flush      = (t.flush_at != 0) && (c == t.flush_at);
      md_resultRDY = is_rdy || (t.stale_rdy && c == 1);
      md_exception = is_rdy ? t.exc : 1'($urandom);
      md_result    = is_rdy ? t.result : $urandom;
      @(negedge clock);
      chk($sformatf("%s.c%0d.stall", tag, c), 32'(stall), 32'(c < last));
      chk($sformatf("%s.c%0d.ctrl_mult", tag, c), 32'(md_ctrl_mult), 32'(c == 1 && t.e_mult));
      chk($sformatf("%s.c%0d.ctrl_div", tag, c), 32'(md_ctrl_div), 32'(c == 1 && !t.e_mult));
      chk($sformatf("%s.c%0d.wb_valid", tag, c), 32'(wb_valid),
          32'(!flushed && c == t.e_done && t.e_valid));
      if (!flushed && c == t.e_done) begin
        chk($sformatf("%s.c%0d.wb_rd", tag, c), 32'(wb_rd), 32'(t.e_rd));
        chk($sformatf("%s.c%0d.wb_data", tag, c), wb_data, t.e_data);
      end
      if (c >= 1 && c <= (flushed ? t.flush_at : t.e_done)) begin
        chk($sformatf("%s.c%0d.md_opA", tag, c), md_opA, t.a);
        chk($sformatf("%s.c%0d.md_opB", tag, c), md_opB, t.b);
      end
      @(posedge clock);
      #1;
    end
    x_is_mult = 1'b0;  x_is_div = 1'b0;  x_flush = 1'b0;  md_resultRDY = 1'b0;
    $display("txn %s: op=%s rd=%0d rdy_at=%0d flush_at=%0d -> done=%0d wb_valid=%0d wb_rd=%0d wb_data=0x%08h",
             tag, t.e_mult ? "MULT" : "DIV", t.rd, t.rdy_at, t.flush_at, t.e_done,
             t.e_valid, t.e_rd, t.e_data);
  endtask

  // IDLE cycles with noise: any request is paired with a flush, so nothing issues.
  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      x_is_mult    = 1'($urandom);
      x_is_div     = 1'($urandom);
      x_flush      = x_is_mult | x_is_div;
      md_resultRDY = 1'($urandom);
      md_exception = 1'($urandom);
      md_result    = $urandom;
      x_opA        = $urandom;
      x_opB        = $urandom;
      @(negedge clock);
      chk($sformatf("idle%0d.stall", i), 32'(stall), 32'd0);
      chk($sformatf("idle%0d.wb_valid", i), 32'(wb_valid), 32'd0);
      chk($sformatf("idle%0d.ctrl_mult", i), 32'(md_ctrl_mult), 32'd0);
      chk($sformatf("idle%0d.ctrl_div", i), 32'(md_ctrl_div), 32'd0);
      @(posedge clock);
      #1;
    end
    x_is_mult = 1'b0;  x_is_div = 1'b0;  x_flush = 1'b0;  md_resultRDY = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".md_opA"}, md_opA, 32'd0);
    chk({tag, ".md_opB"}, md_opB, 32'd0);
    chk({tag, ".ctrl_mult"}, 32'(md_ctrl_mult), 32'd0);
    chk({tag, ".ctrl_div"}, 32'(md_ctrl_div), 32'd0);
    chk({tag, ".wb_valid"}, 32'(wb_valid), 32'd0);
    chk({tag, ".wb_rd"}, 32'(wb_rd), 32'd0);
    chk({tag, ".wb_data"}, wb_data, 32'd0);
    chk({tag, ".stall"}, 32'(stall), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish, checks=%0d failures=%0d", checks, failures);
    $fatal(1, "time limit");
  end

  txn_t vec[13];
  txn_t rt;

  initial begin
    vec[0]  = mk(1,0, 5, 32'd7, 32'hFFFFFFFD, 34,0, 32'hFFFFFFEB, 0,0, 35,1,1, 5, 32'hFFFFFFEB);
    vec[1]  = mk(0,1, 3, 32'd100, 32'd0, 2,1, 32'hDEADBEEF, 0,0, 3,0,1, 30, 32'd5);
    vec[2]  = mk(1,0, 8, 32'h40000000, 32'd4, 6,1, 32'd0, 0,1, 7,1,1, 30, 32'd4);
    vec[3]  = mk(1,0, 9, 32'd1, 32'd2, 0,0, 32'd0, 0,0, 42,1,1, 30, 32'd4);
    vec[4]  = mk(0,1, 11, 32'd9, 32'd3, 0,0, 32'd0, 0,1, 42,0,1, 30, 32'd5);
    vec[5]  = mk(1,0, 12, 32'd5, 32'd6, 0,0, 32'd0, 10,0, 0,1,0, 0, 32'd0);
    vec[6]  = mk(0,1, 13, 32'd75, 32'd3, 2,0, 32'd25, 0,0, 3,0,1, 13, 32'd25);
    vec[7]  = mk(1,0, 0, 32'd3, 32'd3, 3,0, 32'd9, 0,0, 4,1,0, 0, 32'd9);
    vec[8]  = mk(0,1, 0, 32'd1, 32'd0, 3,1, 32'd0, 0,0, 4,0,1, 30, 32'd5);
    vec[9]  = mk(1,0, 4, 32'h1234, 32'd1, 41,0, 32'h1234, 0,0, 42,1,1, 4, 32'h1234);
    vec[10] = mk(1,1, 14, 32'd2, 32'd3, 2,1, 32'd6, 0,0, 3,1,1, 30, 32'd4);
    vec[11] = mk(0,1, 15, 32'd8, 32'd2, 0,0, 32'd0, 1,1, 0,0,0, 0, 32'd0);
    vec[12] = mk(0,1, 16, 32'd9, 32'd3, 5,0, 32'd3, 4,0, 0,0,0, 0, 32'd0);

    // Reset state, including stall following x_is_* while held in reset
    x_opA = 32'hFFFF_FFFF;
    x_opB = 32'h1234_5678;
    #2 reset_n = 1'b0;
    #1 chk_all_zero("reset");
    x_is_mult = 1'b1;
    #1 chk("reset.stall_req", 32'(stall), 32'd1);
    #2 chk("reset.held_ctrl_mult", 32'(md_ctrl_mult), 32'd0);
    chk("reset.held_md_opA", md_opA, 32'd0);
    #2 reset_n = 1'b1;
    x_is_mult = 1'b0;
    @(posedge clock);
    #1;

    for (int i = 0; i < 13; i++) run_txn(vec[i], $sformatf("vec%0d", i));

    // Asynchronous reset in BUSY cycle 5, then a fresh MULT
    idle_cycles(1);
    x_is_mult = 1'b1;  x_rd = 5'd6;  x_opA = 32'hA5A5_0001;  x_opB = 32'h5A5A_0002;
    repeat (5) begin
      @(posedge clock);
      #1;
    end
    chk("midrst.pre_stall", 32'(stall), 32'd1);
    chk("midrst.pre_md_opA", md_opA, 32'hA5A5_0001);
    #2 reset_n = 1'b0;
    x_is_mult = 1'b0;
    #1 chk_all_zero("midrst");
    @(posedge clock);
    #1 chk_all_zero("midrst.held");
    #3 reset_n = 1'b1;
    @(posedge clock);
    #1;
    run_txn(mk(1,0, 6, 32'd11, 32'd12, 3,0, 32'd132, 0,0, 4,1,1, 6, 32'd132), "after_rst");

    // Random transactions against the reference model
    for (int i = 0; i < 60; i++) begin
      int sel;
      sel = int'($urandom_range(0, 2));
      rt.is_mult = (sel != 1);
      rt.is_div  = (sel != 0);
      rt.rd      = 5'($urandom);
      rt.a       = $urandom;
      rt.b       = $urandom;
      case ($urandom_range(0, 9))
        0:       rt.rdy_at = 0;
        1:       rt.rdy_at = int'($urandom_range(38, 45));
        default: rt.rdy_at = int'($urandom_range(2, 12));
      endcase
      rt.exc       = ($urandom_range(0, 3) == 0);
      rt.result    = $urandom;
      rt.flush_at  = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 44)) : 0;
      rt.stale_rdy = 1'($urandom);
      rt = model(rt);
      run_txn(rt, $sformatf("rnd%0d", i));
      idle_cycles(int'($urandom_range(0, 2)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
